// File: rtl/datapath_pkg.sv
// Shared opcode encoding and signed range / narrowing helpers for the datapath pipe.
package datapath_pkg;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_AND  = 3'b010,
    OP_OR   = 3'b011,
    OP_XOR  = 3'b100,
    OP_MAC  = 3'b101,
    OP_ACLR = 3'b110,
    OP_PASS = 3'b111
  } opcode_t;

  // Working width for range checks; must cover the accumulator width.
  localparam int unsigned MAX_W = 128;

  // Largest signed value representable in n bits.
  function automatic logic signed [MAX_W-1:0] range_hi(input int unsigned n);
    return (MAX_W'(1) <<< (n - 1)) - MAX_W'(1);
  endfunction

  // Smallest signed value representable in n bits.
  function automatic logic signed [MAX_W-1:0] range_lo(input int unsigned n);
    return -range_hi(n) - MAX_W'(1);
  endfunction

  // True when value does not fit an n-bit signed result.
  function automatic logic out_of_range(input logic signed [MAX_W-1:0] value,
                                        input int unsigned n);
    return (value > range_hi(n)) || (value < range_lo(n));
  endfunction

  // Clamp to the n-bit signed range when sat is set; caller keeps the low n bits.
  function automatic logic signed [MAX_W-1:0] sat_narrow(input logic signed [MAX_W-1:0] value,
                                                         input int unsigned n,
                                                         input logic sat);
    logic signed [MAX_W-1:0] res;
    res = value;
    if (sat && (value > range_hi(n))) begin
      res = range_hi(n);
    end else if (sat && (value < range_lo(n))) begin
      res = range_lo(n);
    end
    return res;
  endfunction

endpackage

// File: rtl/datapath_alu_core.sv
// Combinational N-bit ADD/SUB/logic/PASS unit with carry, overflow and exact result.
module datapath_alu_core
  import datapath_pkg::*;
#(
  parameter int unsigned N = 16
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  opcode_t      op,
  output logic [N:0]   res_c,
  output logic         co_c,
  output logic         ovf_c
);

  localparam int unsigned W1 = N + 1;

  logic         sub;
  logic [N-1:0] b_x;
  logic [N:0]   sum_u;
  logic [N:0]   sum_s;

  // SUB reuses the adder as A + ~B + 1; sum_s is the exact (N+1)-bit signed result.
  always_comb begin
    sub   = (op == OP_SUB);
    b_x   = sub ? ~b : b;
    sum_u = {1'b0, a} + {1'b0, b_x} + W1'(sub);
    sum_s = {a[N-1], a} + {b_x[N-1], b_x} + W1'(sub);
    res_c = '0;
    co_c  = 1'b0;
    ovf_c = 1'b0;
    unique case (op)
      OP_ADD, OP_SUB: begin
        res_c = sum_s;
        co_c  = sum_u[N];
        ovf_c = (a[N-1] == b_x[N-1]) && (sum_u[N-1] != a[N-1]);
      end
      OP_AND:  res_c = {a[N-1] & b[N-1], a & b};
      OP_OR:   res_c = {a[N-1] | b[N-1], a | b};
      OP_XOR:  res_c = {a[N-1] ^ b[N-1], a ^ b};
      OP_PASS: res_c = {a[N-1], a};
      default: res_c = '0;
    endcase
  end

endmodule

// File: rtl/datapath_pipe.sv
// Two-stage pipelined signed datapath with MAC accumulator, optional saturation and valid/ready.
module datapath_pipe
  import datapath_pkg::*;
#(
  parameter int unsigned N     = 16,
  parameter int unsigned ACC_W = 2 * N + 8,
  parameter bit          SAT   = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic [2:0]   opcode,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] Y,
  output logic         co,
  output logic         ovf,
  output logic         zero
);

  localparam int unsigned PROD_W = 2 * N;

  // Stage 1: captured operands plus accumulator snapshot for MAC/ACLR
  logic             s1_valid_q, s1_valid_d;
  logic [N-1:0]     s1_a_q, s1_a_d;
  logic [N-1:0]     s1_b_q, s1_b_d;
  opcode_t          s1_op_q, s1_op_d;
  logic [ACC_W-1:0] s1_acc_q, s1_acc_d;
  logic [ACC_W-1:0] acc_q, acc_d;

  // Stage 2: output register
  logic             out_valid_q, out_valid_d;
  logic [N-1:0]     y_q, y_d;
  logic             co_q, co_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;

  logic                      advance_c;
  logic                      accept_c;
  logic signed [PROD_W-1:0]  prod_c;
  logic [ACC_W-1:0]          acc_mac_c;
  logic [N:0]                alu_res_c;
  logic                      alu_co_c;
  logic                      alu_ovf_c;
  logic signed [MAX_W-1:0]   wide_c;
  logic signed [MAX_W-1:0]   narrowed_c;
  logic [N-1:0]              y_n_c;
  logic                      co_n_c;
  logic                      ovf_n_c;
  logic                      unused_narrow_hi;

  assign advance_c = !out_valid_q || out_ready;
  assign accept_c  = in_valid && advance_c;
  assign in_ready  = advance_c;

  // Signed product and accumulator sum; the accumulator wraps modulo 2^ACC_W.
  assign prod_c    = PROD_W'($signed(A)) * PROD_W'($signed(B));
  assign acc_mac_c = acc_q + ACC_W'(prod_c);

  datapath_alu_core #(.N(N)) u_alu (
    .a     (s1_a_q),
    .b     (s1_b_q),
    .op    (s1_op_q),
    .res_c (alu_res_c),
    .co_c  (alu_co_c),
    .ovf_c (alu_ovf_c)
  );

  // Stage-2 result select, range flag and narrowing; flags use the unclamped value.
  always_comb begin
    wide_c  = MAX_W'($signed(alu_res_c));
    co_n_c  = alu_co_c;
    ovf_n_c = alu_ovf_c;
    if ((s1_op_q == OP_MAC) || (s1_op_q == OP_ACLR)) begin
      wide_c  = MAX_W'($signed(s1_acc_q));
      co_n_c  = 1'b0;
      ovf_n_c = out_of_range(wide_c, N);
    end
    narrowed_c = sat_narrow(wide_c, N, SAT);
    y_n_c      = narrowed_c[N-1:0];
  end

  assign unused_narrow_hi = ^narrowed_c[MAX_W-1:N];

  // Next state: everything moves only on advance; the accumulator only on accept.
  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_a_d      = s1_a_q;
    s1_b_d      = s1_b_q;
    s1_op_d     = s1_op_q;
    s1_acc_d    = s1_acc_q;
    acc_d       = acc_q;
    out_valid_d = out_valid_q;
    y_d         = y_q;
    co_d        = co_q;
    ovf_d       = ovf_q;
    zero_d      = zero_q;
    if (advance_c) begin
      s1_valid_d  = in_valid;
      out_valid_d = s1_valid_q;
      if (accept_c) begin
        s1_a_d   = A;
        s1_b_d   = B;
        s1_op_d  = opcode_t'(opcode);
        s1_acc_d = acc_q;
        if (opcode_t'(opcode) == OP_MAC) begin
          s1_acc_d = acc_mac_c;
          acc_d    = acc_mac_c;
        end else if (opcode_t'(opcode) == OP_ACLR) begin
          acc_d = '0;
        end
      end
      if (s1_valid_q) begin
        y_d    = y_n_c;
        co_d   = co_n_c;
        ovf_d  = ovf_n_c;
        zero_d = (y_n_c == '0);
      end
    end
  end

  // Pipeline and accumulator registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_op_q     <= OP_ADD;
      s1_acc_q    <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      y_q         <= '0;
      co_q        <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      s1_op_q     <= s1_op_d;
      s1_acc_q    <= s1_acc_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      y_q         <= y_d;
      co_q        <= co_d;
      ovf_q       <= ovf_d;
      zero_q      <= zero_d;
    end
  end

  assign out_valid = out_valid_q;
  assign Y         = y_q;
  assign co        = co_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_datapath_pipe.sv
// Directed bench: a wrapping and a saturating instance driven by the same stimulus.
module tb_datapath_pipe;
  import datapath_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        out_ready;
  logic [15:0] A;
  logic [15:0] B;
  logic [2:0]  opcode;

  logic        in_ready_w, out_valid_w, co_w, ovf_w, zero_w;
  logic [15:0] y_w;
  logic        in_ready_s, out_valid_s, co_s, ovf_s, zero_s;
  logic [15:0] y_s;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  datapath_pipe #(.N(16), .ACC_W(40), .SAT(1'b0)) u_wrap (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w),
    .A(A), .B(B), .opcode(opcode), .out_valid(out_valid_w), .out_ready(out_ready),
    .Y(y_w), .co(co_w), .ovf(ovf_w), .zero(zero_w)
  );

  datapath_pipe #(.N(16), .ACC_W(40), .SAT(1'b1)) u_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s),
    .A(A), .B(B), .opcode(opcode), .out_valid(out_valid_s), .out_ready(out_ready),
    .Y(y_s), .co(co_s), .ovf(ovf_s), .zero(zero_s)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic drive(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    in_valid = 1'b1;
    opcode   = op;
    A        = a;
    B        = b;
  endtask

  // Issue one transaction and advance to the cycle its result is presented.
  task automatic run_op(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    drive(op, a, b);
    tick();
    in_valid = 1'b0;
    tick();
  endtask

  task automatic chk_both(input string tag, input logic [15:0] yw, input logic [15:0] ys,
                          input logic ov, input logic c, input logic z);
    chk({tag, "_valid_w"}, 32'(out_valid_w), 32'd1);
    chk({tag, "_valid_s"}, 32'(out_valid_s), 32'd1);
    chk({tag, "_y_w"},     32'(y_w), 32'(yw));
    chk({tag, "_y_s"},     32'(y_s), 32'(ys));
    chk({tag, "_ovf_w"},   32'(ovf_w), 32'(ov));
    chk({tag, "_ovf_s"},   32'(ovf_s), 32'(ov));
    chk({tag, "_co_w"},    32'(co_w), 32'(c));
    chk({tag, "_co_s"},    32'(co_s), 32'(c));
    chk({tag, "_zero_w"},  32'(zero_w), 32'(z));
    chk({tag, "_zero_s"},  32'(zero_s), 32'(z));
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    A         = '0;
    B         = '0;
    opcode    = OP_ADD;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    chk("rst_valid", 32'(out_valid_w), 32'd0);
    chk("rst_y",     32'(y_w), 32'd0);
    chk("rst_flags", 32'({co_w, ovf_w, zero_w}), 32'd0);
    chk("rst_ready", 32'({in_ready_w, in_ready_s}), 32'd3);

    // ADD overflow with two-edge latency, then drain
    drive(OP_ADD, 16'h7FFF, 16'h0001);
    tick();
    in_valid = 1'b0;
    chk("add_lat_stage1", 32'(out_valid_w), 32'd0);
    tick();
    chk_both("add_pos_ovf", 16'h8000, 16'h7FFF, 1'b1, 1'b0, 1'b0);
    tick();
    chk("add_drain", 32'({out_valid_w, out_valid_s}), 32'd0);

    // Negative overflow saturates low
    run_op(OP_ADD, 16'h8000, 16'hFFFF);
    chk_both("add_neg_ovf", 16'h7FFF, 16'h8000, 1'b1, 1'b1, 1'b0);

    run_op(OP_SUB, 16'd5, 16'd7);
    chk_both("sub_5_7", 16'hFFFE, 16'hFFFE, 1'b0, 1'b0, 1'b0);
    run_op(OP_SUB, 16'd7, 16'd5);
    chk_both("sub_7_5", 16'h0002, 16'h0002, 1'b0, 1'b1, 1'b0);

    // ACLR then back-to-back MACs
    drive(OP_ACLR, 16'd0, 16'd0);
    tick();
    drive(OP_MAC, 16'd3, 16'd4);
    tick();
    chk_both("aclr_init", 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1);
    drive(OP_MAC, 16'hFFFE, 16'd5);
    tick();
    chk_both("mac_12", 16'd12, 16'd12, 1'b0, 1'b0, 1'b0);
    in_valid = 1'b0;
    tick();
    chk_both("mac_2", 16'd2, 16'd2, 1'b0, 1'b0, 1'b0);
    run_op(OP_MAC, 16'd200, 16'd200);
    chk_both("mac_40002", 16'h9C42, 16'h7FFF, 1'b1, 1'b0, 1'b0);

    // Logic ops and PASS
    run_op(OP_AND, 16'hF0F0, 16'h0F0F);
    chk_both("and_zero", 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1);
    run_op(OP_OR, 16'hF0F0, 16'h0F0F);
    chk_both("or", 16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 1'b0);
    run_op(OP_XOR, 16'h1234, 16'hFFFF);
    chk_both("xor", 16'hEDCB, 16'hEDCB, 1'b0, 1'b0, 1'b0);
    run_op(OP_PASS, 16'h8000, 16'h1234);
    chk_both("pass", 16'h8000, 16'h8000, 1'b0, 1'b0, 1'b0);

    // ACLR reports the big accumulator, next-cycle MAC starts from zero
    drive(OP_ACLR, 16'd0, 16'd0);
    tick();
    drive(OP_MAC, 16'd1, 16'd1);
    tick();
    in_valid = 1'b0;
    chk_both("aclr_big", 16'h9C42, 16'h7FFF, 1'b1, 1'b0, 1'b0);
    tick();
    chk_both("mac_after_clr", 16'd1, 16'd1, 1'b0, 1'b0, 1'b0);

    // Backpressure: hold output for four cycles, then drain in order
    drive(OP_ADD, 16'd1, 16'd1);
    tick();
    drive(OP_ADD, 16'd2, 16'd2);
    tick();
    chk("bp_first_y", 32'(y_w), 32'd2);
    out_ready = 1'b0;
    drive(OP_ADD, 16'd3, 16'd3);
    #1;
    chk("bp_ready_low", 32'(in_ready_w), 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("bp_hold_valid", 32'(out_valid_w), 32'd1);
      chk("bp_hold_y", 32'(y_w), 32'd2);
      chk("bp_hold_ready", 32'({in_ready_w, in_ready_s}), 32'd0);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_ready_high", 32'(in_ready_w), 32'd1);
    tick();
    in_valid = 1'b0;
    chk_both("bp_y4", 16'd4, 16'd4, 1'b0, 1'b0, 1'b0);
    tick();
    chk_both("bp_y6", 16'd6, 16'd6, 1'b0, 1'b0, 1'b0);
    tick();
    chk("bp_no_dup", 32'({out_valid_w, out_valid_s}), 32'd0);

    // Reset with both stages full and a MAC in flight
    drive(OP_ADD, 16'd9, 16'd9);
    tick();
    drive(OP_ADD, 16'd8, 16'd8);
    tick();
    drive(OP_MAC, 16'd7, 16'd7);
    tick();
    chk("rstmid_pre_y", 32'(y_w), 32'd16);
    in_valid = 1'b0;
    rst      = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstmid_valid", 32'({out_valid_w, out_valid_s}), 32'd0);
    chk("rstmid_y", 32'(y_w), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rstmid_none", 32'({out_valid_w, out_valid_s}), 32'd0);
    end
    run_op(OP_ACLR, 16'd0, 16'd0);
    chk_both("rstmid_aclr", 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
